control_sequencer: RTL and testbench

- Hardwired control unit for the single-bus datapath. It sits directly upstream of the datapath and drives its control strobes: PCout, Zlowout, MDRout, MDRin, IRin, Yin, Read, and the register-select strobes.
- It steps through fetch (T0–T2) and execute (T3–T5) for register-to-register ALU instructions, plus NOP and HALT, using IR contents fed back from the datapath.
- It also provides a start/stop run handshake and a retired-instruction counter.

---
 rtl/control_sequencer.sv | 109 ++++++++++
 tb/tb_control_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for the single-bus datapath.
// Optional single-step mode (PAUSE state, step port) when SEQ_SINGLE_STEP_EN is defined.
module control_sequencer #(
    parameter int         CNT_W   = 16,
    parameter logic [4:0] NOP_OP  = 5'b11010,
    parameter logic [4:0] HALT_OP = 5'b11011
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [4:0]       alu_op,
    output logic             run,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_PAUSE} state_t;
    localparam state_t S_NEXT = S_PAUSE;
`else
    typedef enum logic [2:0] {S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5} state_t;
    localparam state_t S_NEXT = S_T0;
`endif
    state_t state;
    logic stop_pend;
    logic [4:0] op;
    logic legal, retire, go_halt, unused_ir;
    assign op = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign legal = op >= 5'd3 && op <= 5'd10;
    assign retire = (state == S_T3 && !legal) || state == S_T5;
    assign go_halt = stop_pend || (state == S_T3 && op == HALT_OP);
    always_ff @(posedge clock) begin
        if (!clear) begin
            state       <= S_HALT;
            stop_pend   <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (run && stop)
                stop_pend <= 1'b1;
            case (state)
                S_HALT: if (start) begin
                    state     <= S_T0;
                    stop_pend <= stop;
                end
                S_T0: state <= S_T1;
                S_T1: if (mem_ready) state <= S_T2;
                S_T2: state <= S_T3;
                S_T3: if (legal) state <= S_T4;
                      else if (op != NOP_OP && op != HALT_OP) illegal <= 1'b1;
                S_T4: state <= S_T5;
                S_T5: ;
`ifdef SEQ_SINGLE_STEP_EN
                S_PAUSE: if (stop_pend) begin
                    state     <= S_HALT;
                    stop_pend <= 1'b0;
                end else if (step) state <= S_T0;
`endif
                default: state <= S_HALT;
            endcase
            // A pending stop is only honoured once the instruction has retired.
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
                state       <= go_halt ? S_HALT : S_NEXT;
                if (go_halt) stop_pend <= 1'b0;
            end
        end
    end
    assign run     = state != S_HALT;
    assign PCout   = state == S_T0;
    assign MARin   = state == S_T0;
    assign IncPC   = state == S_T0;
    assign Zin     = state == S_T0 || state == S_T4;
    assign PCin    = state == S_T1;
    assign Read    = state == S_T1;
    assign MDRin   = state == S_T1;
    assign Zlowout = state == S_T1 || state == S_T5;
    assign MDRout  = state == S_T2;
    assign IRin    = state == S_T2;
    assign Yin     = state == S_T3 && legal;
    assign Grb     = state == S_T3 && legal;
    assign Rout    = (state == S_T3 && legal) || state == S_T4;
    assign Grc     = state == S_T4;
    assign Gra     = state == S_T5;
    assign Rin     = state == S_T5;
    assign alu_op  = state == S_T4 ? op : 5'd0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; expected per-cycle strobes, count and illegal flag are queued as inputs are driven.
module tb_control_sequencer;
    localparam int CW = 4;
    // strobe order: PCout MARin IncPC PCin Zin Zlowout Read MDRin MDRout IRin Yin Gra Grb Grc Rin Rout run
    localparam logic [16:0] E_HALT = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_T0   = 17'b1_1_1_0_1_0_0_0_0_0_0_0_0_0_0_0_1;
    localparam logic [16:0] E_T1   = 17'b0_0_0_1_0_1_1_1_0_0_0_0_0_0_0_0_1;
    localparam logic [16:0] E_T2   = 17'b0_0_0_0_0_0_0_0_1_1_0_0_0_0_0_0_1;
    localparam logic [16:0] E_T3A  = 17'b0_0_0_0_0_0_0_0_0_0_1_0_1_0_0_1_1;
    localparam logic [16:0] E_T3N  = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_1;
    localparam logic [16:0] E_T4   = 17'b0_0_0_0_1_0_0_0_0_0_0_0_0_1_0_1_1;
    localparam logic [16:0] E_T5   = 17'b0_0_0_0_0_1_0_0_0_0_0_1_0_0_1_0_1;
    logic clock = 0, clear = 0, start = 0, stop = 0, mem_ready = 0;
    logic [31:0] ir = 0;
    logic PCout, MARin, IncPC, PCin, Zin, Zlowout, Read, MDRin, MDRout, IRin, Yin;
    logic Gra, Grb, Grc, Rin, Rout, run, illegal;
    logic [4:0] alu_op;
    logic [CW-1:0] instr_count;
    typedef struct {string tag; logic [26:0] v;} exp_t;
    exp_t exp_q[$];
    exp_t cur;
    int n_chk = 0, n_fail = 0;
    logic [CW-1:0] cnt = 0;
    logic ill = 0, pend = 0;
    logic [26:0] obs;
    control_sequencer #(.CNT_W(CW)) dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Zin(Zin), .Zlowout(Zlowout),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run), .illegal(illegal),
        .instr_count(instr_count)
    );
    always #5 clock = ~clock;
    assign obs = {PCout, MARin, IncPC, PCin, Zin, Zlowout, Read, MDRin, MDRout, IRin, Yin,
                  Gra, Grb, Grc, Rin, Rout, run, alu_op, instr_count, illegal};
    task automatic check(input string tag, input logic [26:0] got, input logic [26:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check(cur.tag, obs, cur.v);
        end
    end
    task automatic cyc(input string tag, input logic cl, input logic st, input logic sp, input logic mr,
                       input logic [16:0] s, input logic [4:0] a);
        @(negedge clock);
        clear = cl; start = st; stop = sp; mem_ready = mr;
        exp_q.push_back('{tag: tag, v: {s, a, cnt, ill}});
    endtask
    task automatic go(input logic sp);
        pend = sp;
        cyc("start", 1, 1, sp, 0, E_T0, 5'd0);
    endtask
    // Called while the DUT is in T0; leaves it in T0 or HALT after retire.
    task automatic instr(input string nm, input logic [31:0] iv, input int waits, input logic stp3);
        logic [4:0] op;
        logic legal, halt_next;
        op = iv[31:27];
        legal = op >= 5'd3 && op <= 5'd10;
        cyc({nm, ":T1"}, 1, 0, 0, 0, E_T1, 5'd0);
        ir = iv;
        for (int w = 0; w < waits; w++) cyc({nm, ":T1wait"}, 1, 0, 0, 0, E_T1, 5'd0);
        cyc({nm, ":T2"}, 1, 0, 0, 1, E_T2, 5'd0);
        cyc({nm, ":T3"}, 1, 0, 0, 0, legal ? E_T3A : E_T3N, 5'd0);
        if (legal) begin
            if (stp3) pend = 1;
            cyc({nm, ":T4"}, 1, 0, stp3, 0, E_T4, op);
            cyc({nm, ":T5"}, 1, 0, 0, 0, E_T5, 5'd0);
        end else if (op != 5'b11010 && op != 5'b11011) ill = 1;
        halt_next = pend || (!legal && op == 5'b11011);
        if (halt_next) pend = 0;
        cnt = cnt + 1'b1;
        cyc({nm, ":retire"}, 1, 0, 0, 0, halt_next ? E_HALT : E_T0, 5'd0);
    endtask
    initial begin
        cyc("rst0", 0, 0, 0, 0, E_HALT, 5'd0);
        cyc("rst_prio", 0, 1, 1, 1, E_HALT, 5'd0);
        cyc("idle", 1, 0, 0, 1, E_HALT, 5'd0);
        cyc("idle_stop", 1, 0, 1, 0, E_HALT, 5'd0);
        go(0);
        instr("alu", 32'h28918000, 0, 0);
        instr("alu_wait", 32'h28918000, 3, 0);
        instr("nop", 32'hD0000000, 0, 0);
        instr("alu_stop", 32'h28918000, 0, 1);
        cyc("halted", 1, 0, 0, 1, E_HALT, 5'd0);
        go(0);
        instr("halt_op", 32'hD8000000, 0, 0);
        cyc("halted2", 1, 0, 0, 0, E_HALT, 5'd0);
        go(0);
        instr("illegal", 32'hF8000000, 0, 0);
        instr("nop_sticky", 32'hD0000000, 0, 0);
        cyc("mf_T1", 1, 0, 0, 0, E_T1, 5'd0);
        cyc("mf_stall", 1, 1, 0, 0, E_T1, 5'd0);
        cnt = 0; ill = 0; pend = 0;
        cyc("mf_reset", 0, 1, 1, 1, E_HALT, 5'd0);
        cyc("mf_idle", 1, 0, 0, 1, E_HALT, 5'd0);
        go(1);
        instr("start_stop", 32'hD0000000, 0, 0);
        cyc("ss_halted", 1, 0, 0, 0, E_HALT, 5'd0);
        go(0);
        for (int i = 0; i < 15; i++) instr("wrap", 32'hD0000000, 0, 0);
        cnt = 0; ill = 0; pend = 0;
        cyc("fin_reset", 0, 0, 0, 0, E_HALT, 5'd0);
        @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expected 0 pending entries", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
